vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 640x480@60 pixel-address counter.
- Generates the pixel column/row address, hsync/vsync with configurable polarity, a visible-area flag, and line/frame end strobes.
- Sits between the pixel-clock domain and the framebuffer read / pixel output stages.
- Any VGA mode is selected by parameters alone.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines
- H_SYNC_POL, 0, active level of hsync (0 = active-low)
- V_SYNC_POL, 0, active level of vsync
- COL_BITS, 10, width of column; must hold H_TOTAL-1
- ROW_BITS, 10, width of row; must hold V_TOTAL-1

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  advance counters this cycle when high
- column  out  COL_BITS  current pixel column
- row  out  ROW_BITS  current line
- hsync  out  1  horizontal sync, polarity H_SYNC_POL
- vsync  out  1  vertical sync, polarity V_SYNC_POL
- visible  out  1  high when column < H_VISIBLE and row < V_VISIBLE
- line_end  out  1  strobe: enable high and column == H_TOTAL-1
- frame_end  out  1  strobe: line_end high and row == V_TOTAL-1

Behaviour:
- Derived constants:
  - H_TOTAL = sum of all H_* timing parameters.
  - V_TOTAL = sum of all V_* timing parameters.
  - Defaults give 800 x 525.
- Reset (asynchronous assertion when reset low, synchronous release), all outputs held:
  - column = 0, row = 0
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL
  - visible = 1
  - line_end = 0, frame_end = 0
- Counting:
  - On each rising clk with enable high, column increments.
  - At column == H_TOTAL-1, column wraps to 0 and row increments.
  - At row == V_TOTAL-1 with a column wrap, row wraps to 0.
  - With enable low, all registered outputs hold their value.
- Registered decodes (hsync, vsync, visible):
  - Registered from next-state counter values, so they are aligned with column/row in the same cycle: zero latency relative to the address.
  - hsync active when column is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1].
  - vsync active when row is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1].
  - vsync changes only on the column 0 boundary.
- Strobes: line_end and frame_end are combinational from registered state and enable. With enable low they are 0.
- Width rules:
  - Comparisons are done at counter width.
  - Elaboration fails (generate-time error) if H_TOTAL > 2**COL_BITS or V_TOTAL > 2**ROW_BITS.
- Reset mid-frame: outputs return to their reset values immediately; counting restarts from (0,0) on the first enabled edge after release.
- enable dropping at the wrap cycle: the wrap is deferred until the next enabled edge. No skipped or duplicated addresses.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- When defined:
  - Adds output frame_count (16 bits), reset to 0.
  - frame_count increments on every cycle where frame_end is high, wrapping from 65535 to 0.
  - Used by animation/test-pattern logic.
- When undefined: no port and no register. All other behaviour is identical.

Test Plan:
- Reset and first pixels, defaults: hold reset low -> column=0, row=0, hsync=1, vsync=1, visible=1; release, 2 enabled clocks -> column=2, row=0.
- Line and sync, defaults:
  - column 639 -> visible=1; column 640 -> visible=0.
  - hsync=0 exactly for columns 656..751.
  - column 799 -> line_end=1; next clock -> column=0, row=1.
- Frame and vsync, defaults:
  - vsync=0 exactly for rows 490..491.
  - row 524, column 799 -> frame_end=1; next clock -> (0,0).
  - Total period is 420000 clocks.
- Enable gating: deassert enable for 5 cycles at column 799 -> column stays 799, line_end=0; re-enable -> wraps to (0, row+1).
- Reset mid-frame: assert reset at row 300, column 400 -> (0,0) immediately, without a clock edge; release -> counting resumes from 0.
- Small mode: H=4/1/2/1, V=3/1/1/1, both polarities 1 -> H_TOTAL=8, V_TOTAL=6, hsync=1 at columns 5..6, vsync=1 at row 4, frame_end every 48 clocks. With VGA_TIMING_FRAME_CNT_EN, frame_count=3 after 144 clocks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel address, syncs, visible flag, line/frame strobes.
// Optional 16-bit frame counter output when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter logic        H_SYNC_POL = 1'b0,
    parameter logic        V_SYNC_POL = 1'b0,
    parameter int unsigned COL_BITS   = 10,
    parameter int unsigned ROW_BITS   = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    output logic [COL_BITS-1:0] column,
    output logic [ROW_BITS-1:0] row,
    output logic                hsync,
    output logic                vsync,
    output logic                visible,
    output logic                line_end,
    output logic                frame_end
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]         frame_count
`endif
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COL_BITS-1:0] H_LAST   = COL_BITS'(H_TOTAL - 1);
    localparam logic [COL_BITS-1:0] H_VIS    = COL_BITS'(H_VISIBLE);
    localparam logic [COL_BITS-1:0] HS_FIRST = COL_BITS'(H_VISIBLE + H_FRONT);
    localparam logic [COL_BITS-1:0] HS_LAST  = COL_BITS'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [ROW_BITS-1:0] V_LAST   = ROW_BITS'(V_TOTAL - 1);
    localparam logic [ROW_BITS-1:0] V_VIS    = ROW_BITS'(V_VISIBLE);
    localparam logic [ROW_BITS-1:0] VS_FIRST = ROW_BITS'(V_VISIBLE + V_FRONT);
    localparam logic [ROW_BITS-1:0] VS_LAST  = ROW_BITS'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    if (H_TOTAL > (2 ** COL_BITS)) begin : g_col_width_chk
        $error("vga_timing_gen: COL_BITS too small for H_TOTAL");
    end
    if (V_TOTAL > (2 ** ROW_BITS)) begin : g_row_width_chk
        $error("vga_timing_gen: ROW_BITS too small for V_TOTAL");
    end

    logic [COL_BITS-1:0] col_nxt;
    logic [ROW_BITS-1:0] row_nxt;
    logic                hsync_nxt;
    logic                vsync_nxt;
    logic                visible_nxt;

    // Decodes look at the next address so they land in the same cycle as it.
    always_comb begin
        col_nxt = column;
        row_nxt = row;
        if (enable) begin
            if (column == H_LAST) begin
                col_nxt = '0;
                row_nxt = (row == V_LAST) ? '0 : row + ROW_BITS'(1);
            end else begin
                col_nxt = column + COL_BITS'(1);
            end
        end
        hsync_nxt   = ((col_nxt >= HS_FIRST) && (col_nxt <= HS_LAST)) ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_nxt   = ((row_nxt >= VS_FIRST) && (row_nxt <= VS_LAST)) ? V_SYNC_POL : ~V_SYNC_POL;
        visible_nxt = (col_nxt < H_VIS) && (row_nxt < V_VIS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            column  <= '0;
            row     <= '0;
            hsync   <= ~H_SYNC_POL;
            vsync   <= ~V_SYNC_POL;
            visible <= 1'b1;
        end else begin
            column  <= col_nxt;
            row     <= row_nxt;
            hsync   <= hsync_nxt;
            vsync   <= vsync_nxt;
            visible <= visible_nxt;
        end
    end

    assign line_end  = enable && (column == H_LAST);
    assign frame_end = line_end && (row == V_LAST);

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_count <= '0;
        end else if (frame_end) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule
